// File: rtl/gray_conv_arbiter_if.sv
// Requester and consumer handshake bundle for the shared Gray-to-binary converter.
// master drives requests and out_ready; slave is the arbiter side.
interface gray_conv_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_gray;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_bin;
  logic [W-1:0]      out_gray;
  logic [IDW-1:0]    out_id;
  logic              busy;

  modport master (
    output req_valid, req_gray, out_ready,
    input  req_ready, out_valid, out_bin, out_gray, out_id, busy
  );

  modport slave (
    input  req_valid, req_gray, out_ready,
    output req_ready, out_valid, out_bin, out_gray, out_id, busy
  );
endinterface

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one Gray-to-binary converter among NREQ requesters,
// with a single-entry registered result stage under valid/ready backpressure.
module gray_conv_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input logic                clk,
  input logic                rst,
  gray_conv_arbiter_if.slave bus
);

  localparam int unsigned SW = IDW + 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;
  logic [W-1:0]   out_bin_q;
  logic [W-1:0]   out_gray_q;
  logic [IDW-1:0] out_id_q;

  logic [W-1:0]    gray_arr [NREQ];
  logic            can_accept_c;
  logic            found_c;
  logic            grant_c;
  logic [IDW-1:0]  win_c;
  logic [SW-1:0]   idx_c;
  logic [W-1:0]    sel_gray_c;
  logic [NREQ-1:0] req_ready_c;

  // MSB passes through; each lower bit is the XOR of all code bits above and including it.
  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b        = '0;
    b[W-1]   = g[W-1];
    for (int i = int'(W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      gray_arr[i] = bus.req_gray[i*W +: W];
    end
  end

  // Search from ptr upward with wrap; the first valid requester wins.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    idx_c   = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      idx_c = {1'b0, ptr_q} + SW'(k);
      if (idx_c >= SW'(NREQ)) begin
        idx_c = idx_c - SW'(NREQ);
      end
      if (!found_c && bus.req_valid[idx_c[IDW-1:0]]) begin
        found_c = 1'b1;
        win_c   = idx_c[IDW-1:0];
      end
    end
  end

  assign can_accept_c = (state_q == EMPTY) | bus.out_ready;
  assign grant_c      = can_accept_c & found_c & ~rst;
  assign sel_gray_c   = gray_arr[win_c];

  always_comb begin
    req_ready_c = '0;
    if (grant_c) begin
      req_ready_c[win_c] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_c) begin
      ptr_d = (win_c == IDW'(NREQ - 1)) ? '0 : win_c + IDW'(1);
    end
  end

  // Output stage occupancy: refill on grant, drain on out_ready without a new grant.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (grant_c) state_d = FULL;
      FULL:  if (bus.out_ready && !grant_c) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Result register is written only on a grant, so it holds through stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_bin_q  <= '0;
      out_gray_q <= '0;
      out_id_q   <= '0;
    end else if (grant_c) begin
      out_bin_q  <= gray2bin(sel_gray_c);
      out_gray_q <= sel_gray_c;
      out_id_q   <= win_c;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_bin   = out_bin_q;
  assign bus.out_gray  = out_gray_q;
  assign bus.out_id    = out_id_q;
  assign bus.busy      = (state_q == FULL) | (|bus.req_valid);

endmodule
